isq_dispatch_tx: RTL and testbench

- Transmit side of the issue-queue enqueue interface. Sits between rename/dispatch and the circular issue queue.
- Accepts renamed instruction packets and computes each packet's 2-bit operand-ready condition from a physical-register busy table.
- Buffers up to two packets in a skid FIFO that drives the queue's enqueue_valid/ready handshake.
- Keeps buffered conditions current by snooping writeback, and drops buffered packets younger than a flush point.

---
 rtl/isq_dispatch_tx.sv | 149 ++++++++++++++
 tb/tb_isq_dispatch_tx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/isq_dispatch_tx.sv
// Issue-queue enqueue transmit stage: two-entry skid FIFO carrying renamed packets,
// with operand-ready conditions from a busy table, writeback snooping and rollback.
module isq_dispatch_tx #(
   parameter int DATA_WIDTH      = 248,
   parameter int PREG_NUM        = 64,
   parameter int ROBID_WIDTH     = 7,
   parameter int CONDITION_WIDTH = 2
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_WIDTH-1:0]      in_data,
   output logic                       enqueue_valid,
   input  logic                       enqueue_ready,
   output logic [DATA_WIDTH-1:0]      enqueue_data,
   output logic [CONDITION_WIDTH-1:0] enqueue_condition,
   input  logic                       wb_valid,
   input  logic [5:0]                 wb_prd,
   input  logic                       flush_valid,
   input  logic [ROBID_WIDTH-1:0]     flush_robid
);

   localparam int ROBID_HI = 247;
   localparam int ROBID_LO = 241;
   localparam int PRD_HI   = 129;
   localparam int PRD_LO   = 124;
   localparam int NEED_WB  = 117;
   localparam int PRS1_HI  = 116;
   localparam int PRS1_LO  = 111;
   localparam int PRS2_HI  = 110;
   localparam int PRS2_LO  = 105;
   localparam int SRC1_REG = 104;
   localparam int SRC2_REG = 103;

   logic [DATA_WIDTH-1:0]      data_r [2];
   logic [CONDITION_WIDTH-1:0] cond_r [2];
   logic                       head_r;
   logic [1:0]                 cnt_r;
   logic [PREG_NUM-1:0]        busy_r;

   logic                       pop_s;
   logic                       push_s;
   logic [1:0]                 occ_s;
   logic [1:0]                 kill_s;
   logic [1:0]                 live_s;
   logic [1:0]                 live_cnt_s;
   logic [1:0]                 cnt_nxt_s;
   logic                       head_nxt_s;
   logic                       tail_s;
   logic [CONDITION_WIDTH-1:0] cond_nxt_s [2];
   logic [CONDITION_WIDTH-1:0] in_cond_s;
   logic [PREG_NUM-1:0]        busy_nxt_s;
   logic [5:0]                 in_prd_s;
   logic [5:0]                 in_prs1_s;
   logic [5:0]                 in_prs2_s;

   // Wrap bit flips the sense of the index comparison across an epoch boundary.
   function automatic logic is_younger(input logic [ROBID_WIDTH-1:0] robid,
                                       input logic [ROBID_WIDTH-1:0] point);
      return (robid[ROBID_WIDTH-1] ^ point[ROBID_WIDTH-1]) ^
             (robid[ROBID_WIDTH-2:0] > point[ROBID_WIDTH-2:0]);
   endfunction

   function automatic logic src_ready(input logic is_reg, input logic [5:0] prs,
                                      input logic busy_bit, input logic wbv,
                                      input logic [5:0] wbp);
      return ~is_reg | (prs == 6'd0) | ~busy_bit | (wbv & (wbp == prs));
   endfunction

   function automatic logic snoop_hit(input logic is_reg, input logic [5:0] prs,
                                      input logic wbv, input logic [5:0] wbp);
      return wbv & is_reg & (wbp == prs);
   endfunction

   assign in_prd_s          = in_data[PRD_HI:PRD_LO];
   assign in_prs1_s         = in_data[PRS1_HI:PRS1_LO];
   assign in_prs2_s         = in_data[PRS2_HI:PRS2_LO];
   assign in_ready          = ~reset & (cnt_r != 2'd2) & ~flush_valid;
   assign enqueue_valid     = (cnt_r != 2'd0);
   assign enqueue_data      = data_r[head_r];
   assign enqueue_condition = cond_r[head_r];

   // Slot survival after pop/flush, pointer compaction and condition snoop
   always_comb begin
      pop_s  = enqueue_valid & enqueue_ready;
      push_s = in_valid & in_ready;
      for (int i = 0; i < 2; i++) begin
         if (1'(i) == head_r) begin
            occ_s[i] = (cnt_r != 2'd0);
         end else begin
            occ_s[i] = (cnt_r == 2'd2);
         end
         kill_s[i] = (pop_s & (1'(i) == head_r)) |
                     (flush_valid & is_younger(data_r[i][ROBID_HI:ROBID_LO], flush_robid));
         live_s[i] = occ_s[i] & ~kill_s[i];
         cond_nxt_s[i] = cond_r[i] |
            {snoop_hit(data_r[i][SRC2_REG], data_r[i][PRS2_HI:PRS2_LO], wb_valid, wb_prd),
             snoop_hit(data_r[i][SRC1_REG], data_r[i][PRS1_HI:PRS1_LO], wb_valid, wb_prd)};
      end
      // A dead head with a live successor makes the successor the new head.
      if (live_s[head_r]) begin
         head_nxt_s = head_r;
      end else if (occ_s[head_r]) begin
         head_nxt_s = ~head_r;
      end else begin
         head_nxt_s = head_r;
      end
      live_cnt_s = {1'b0, live_s[0]} + {1'b0, live_s[1]};
      tail_s     = head_nxt_s ^ live_cnt_s[0];
      cnt_nxt_s  = live_cnt_s + {1'b0, push_s};
   end

   // Incoming packet's ready bits and next busy table (set beats clear, p0 never busy)
   always_comb begin
      in_cond_s = {src_ready(in_data[SRC2_REG], in_prs2_s, busy_r[in_prs2_s], wb_valid, wb_prd),
                   src_ready(in_data[SRC1_REG], in_prs1_s, busy_r[in_prs1_s], wb_valid, wb_prd)};
      for (int i = 0; i < PREG_NUM; i++) begin
         busy_nxt_s[i] = (6'(i) != 6'd0) &
                         ((push_s & in_data[NEED_WB] & (in_prd_s == 6'(i))) |
                          (busy_r[i] & ~(wb_valid & (wb_prd == 6'(i)))));
      end
   end

   // FIFO storage, pointers and busy table
   always_ff @(posedge clock) begin
      if (reset) begin
         head_r <= 1'b0;
         cnt_r  <= 2'd0;
         busy_r <= {PREG_NUM{1'b0}};
         for (int i = 0; i < 2; i++) begin
            data_r[i] <= {DATA_WIDTH{1'b0}};
            cond_r[i] <= {CONDITION_WIDTH{1'b0}};
         end
      end else begin
         head_r <= head_nxt_s;
         cnt_r  <= cnt_nxt_s;
         busy_r <= busy_nxt_s;
         for (int i = 0; i < 2; i++) begin
            cond_r[i] <= cond_nxt_s[i];
         end
         if (push_s) begin
            data_r[tail_s] <= in_data;
            cond_r[tail_s] <= in_cond_s;
         end
      end
   end

endmodule

// File: tb/tb_isq_dispatch_tx.sv
// Bench for isq_dispatch_tx: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based reference model.
module tb_isq_dispatch_tx;
   localparam int DW = 248;

   logic          clock = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          enqueue_valid;
   logic          enqueue_ready;
   logic [DW-1:0] enqueue_data;
   logic [1:0]    enqueue_condition;
   logic          wb_valid;
   logic [5:0]    wb_prd;
   logic          flush_valid;
   logic [6:0]    flush_robid;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [DW-1:0] d;
      logic [1:0]    c;
   } ent_t;

   ent_t mq[$];
   bit   mbusy[64];

   always #5 clock = ~clock;

   isq_dispatch_tx dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .enqueue_valid(enqueue_valid), .enqueue_ready(enqueue_ready),
      .enqueue_data(enqueue_data), .enqueue_condition(enqueue_condition),
      .wb_valid(wb_valid), .wb_prd(wb_prd),
      .flush_valid(flush_valid), .flush_robid(flush_robid)
   );

   function automatic logic [DW-1:0] mk(input logic [6:0] robid, input logic [5:0] prd,
                                        input logic nwb, input logic [5:0] p1,
                                        input logic [5:0] p2, input logic r1, input logic r2);
      logic [DW-1:0] d;
      d = '0;
      for (int i = 0; i < 8; i++) d = (d << 32) | DW'($urandom());
      d[247:241] = robid;
      d[129:124] = prd;
      d[117]     = nwb;
      d[116:111] = p1;
      d[110:105] = p2;
      d[104]     = r1;
      d[103]     = r2;
      return d;
   endfunction

   function automatic bit younger(input logic [6:0] r, input logic [6:0] f);
      return (r[6] ^ f[6]) ^ (r[5:0] > f[5:0]);
   endfunction

   function automatic bit op_ready(input logic is_reg, input logic [5:0] prs);
      return !is_reg || prs == 6'd0 || !mbusy[prs] || (wb_valid && wb_prd == prs);
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic compare();
      logic exp_rdy;
      exp_rdy = !reset && mq.size() < 2 && !flush_valid;
      chk("in_ready", DW'(in_ready), DW'(exp_rdy));
      chk("enq_valid", DW'(enqueue_valid), DW'(mq.size() != 0));
      if (mq.size() != 0) begin
         chk("enq_data", enqueue_data, mq[0].d);
         chk("enq_cond", DW'(enqueue_condition), DW'(mq[0].c));
      end
   endtask

   task automatic model_step();
      ent_t nq[$];
      ent_t e;
      bit   acc;
      bit   pop;
      if (reset) begin
         mq.delete();
         foreach (mbusy[i]) mbusy[i] = 1'b0;
      end else begin
         acc = in_valid && !flush_valid && mq.size() < 2;
         pop = mq.size() != 0 && enqueue_ready;
         e.d = in_data;
         e.c = {op_ready(in_data[103], in_data[110:105]), op_ready(in_data[104], in_data[116:111])};
         if (wb_valid) begin
            foreach (mq[i]) begin
               if (mq[i].d[104] && mq[i].d[116:111] == wb_prd) mq[i].c[0] = 1'b1;
               if (mq[i].d[103] && mq[i].d[110:105] == wb_prd) mq[i].c[1] = 1'b1;
            end
         end
         if (pop) void'(mq.pop_front());
         if (flush_valid) begin
            foreach (mq[i]) if (!younger(mq[i].d[247:241], flush_robid)) nq.push_back(mq[i]);
            mq = nq;
         end
         if (wb_valid && wb_prd != 6'd0) mbusy[wb_prd] = 1'b0;
         if (acc && in_data[117] && in_data[129:124] != 6'd0) mbusy[in_data[129:124]] = 1'b1;
         if (acc) mq.push_back(e);
      end
   endtask

   task automatic tick();
      #1;
      compare();
      model_step();
      @(negedge clock);
   endtask

   task automatic idle();
      in_valid      = 1'b0;
      in_data       = '0;
      enqueue_ready = 1'b0;
      wb_valid      = 1'b0;
      wb_prd        = 6'd0;
      flush_valid   = 1'b0;
      flush_robid   = 7'd0;
   endtask

   initial begin
      logic [DW-1:0] pa, pb;
      reset = 1'b1;
      idle();
      repeat (2) @(negedge clock);
      chk("rst_valid", DW'(enqueue_valid), DW'(1'b0));
      chk("rst_data", enqueue_data, '0);
      chk("rst_cond", DW'(enqueue_condition), DW'(2'b00));
      tick();
      reset = 1'b0;
      #1 chk("ready_after_rst", DW'(in_ready), DW'(1'b1));

      // basic accept, visible next cycle
      pa = mk(7'h05, 6'd0, 1'b0, 6'd3, 6'd4, 1'b1, 1'b1);
      in_valid = 1'b1; in_data = pa; tick(); idle();
      chk("t1_valid", DW'(enqueue_valid), DW'(1'b1));
      chk("t1_cond", DW'(enqueue_condition), DW'(2'b11));
      chk("t1_data", enqueue_data, pa);
      enqueue_ready = 1'b1; tick(); idle();

      // producer/consumer, full FIFO, snoop
      in_valid = 1'b1; in_data = mk(7'h06, 6'd10, 1'b1, 6'd0, 6'd0, 1'b0, 1'b0); tick();
      pb = mk(7'h07, 6'd0, 1'b0, 6'd10, 6'd0, 1'b1, 1'b1);
      in_data = pb; tick(); idle();
      #1 chk("t2_full_ready", DW'(in_ready), DW'(1'b0));
      enqueue_ready = 1'b1; tick(); idle();
      chk("t2_b_cond", DW'(enqueue_condition), DW'(2'b10));
      chk("t2_b_data", enqueue_data, pb);
      wb_valid = 1'b1; wb_prd = 6'd10; tick(); idle();
      chk("t2_b_snoop", DW'(enqueue_condition), DW'(2'b11));
      enqueue_ready = 1'b1; tick(); idle();

      // same-cycle writeback bypass at accept
      in_valid = 1'b1; in_data = mk(7'h08, 6'd7, 1'b1, 6'd0, 6'd0, 1'b0, 1'b0); tick();
      in_data = mk(7'h09, 6'd0, 1'b0, 6'd7, 6'd0, 1'b1, 1'b0);
      wb_valid = 1'b1; wb_prd = 6'd7; enqueue_ready = 1'b1; tick(); idle();
      chk("t3_bypass", DW'(enqueue_condition), DW'(2'b11));
      pb = mk(7'h0A, 6'd0, 1'b0, 6'd7, 6'd0, 1'b1, 1'b0);
      in_valid = 1'b1; in_data = pb; enqueue_ready = 1'b1; tick(); idle();
      chk("t3_busy7_clear", DW'(enqueue_condition), DW'(2'b11));
      chk("t3_e_data", enqueue_data, pb);
      enqueue_ready = 1'b1; tick(); idle();

      // set wins over clear to the same register
      in_valid = 1'b1; in_data = mk(7'h0B, 6'd12, 1'b1, 6'd0, 6'd0, 1'b0, 1'b0);
      wb_valid = 1'b1; wb_prd = 6'd12; tick();
      wb_valid = 1'b0; wb_prd = 6'd0;
      in_data = mk(7'h0C, 6'd0, 1'b0, 6'd12, 6'd0, 1'b1, 1'b0); enqueue_ready = 1'b1; tick(); idle();
      chk("t4_set_wins", DW'(enqueue_condition), DW'(2'b10));
      wb_valid = 1'b1; wb_prd = 6'd12; enqueue_ready = 1'b1; tick(); idle();

      // flush drops the younger entry
      in_valid = 1'b1; in_data = mk(7'h03, 6'd0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0); tick();
      in_data = mk(7'h06, 6'd0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0); tick(); idle();
      flush_valid = 1'b1; flush_robid = 7'h04; in_valid = 1'b1;
      in_data = mk(7'h01, 6'd0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0);
      #1 chk("t5_flush_ready", DW'(in_ready), DW'(1'b0));
      tick(); idle();
      chk("t5_head", DW'(enqueue_data[247:241]), DW'(7'h03));
      enqueue_ready = 1'b1; tick(); idle();
      chk("t5_count1", DW'(enqueue_valid), DW'(1'b0));

      // wrap-bit flush, then mid-stream reset
      in_valid = 1'b1; in_data = mk(7'h3F, 6'd20, 1'b1, 6'd0, 6'd0, 1'b0, 1'b0); tick();
      in_data = mk(7'h40, 6'd0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0); tick(); idle();
      flush_valid = 1'b1; flush_robid = 7'h3F; tick(); idle();
      chk("t6_wrap_head", DW'(enqueue_data[247:241]), DW'(7'h3F));
      reset = 1'b1; tick(); reset = 1'b0; idle();
      chk("t6_rst_valid", DW'(enqueue_valid), DW'(1'b0));
      in_valid = 1'b1; in_data = mk(7'h41, 6'd0, 1'b0, 6'd20, 6'd0, 1'b1, 1'b0); tick(); idle();
      chk("t6_busy_clr", DW'(enqueue_condition), DW'(2'b11));

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         reset         = ($urandom_range(0, 299) == 0);
         in_valid      = ($urandom_range(0, 99) < 70);
         in_data       = mk(7'($urandom_range(0, 127)), 6'($urandom_range(0, 7)),
                            1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
                            6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 1)));
         enqueue_ready = ($urandom_range(0, 99) < 55);
         wb_valid      = ($urandom_range(0, 99) < 40);
         wb_prd        = 6'($urandom_range(0, 7));
         flush_valid   = ($urandom_range(0, 99) < 6);
         flush_robid   = 7'($urandom_range(0, 127));
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
